// File: rtl/ecc_scrubber_pkg.sv
// Shared types for the scrubber plus the (39,32) Hsiao SECDED column table and syndrome classifier.
// Data bit i maps to the i-th 7-bit weight-3 pattern; check bit j maps to the weight-1 pattern 1<<j.
package ecc_scrubber_pkg;

  typedef enum logic [1:0] {IDLE, READ, WB} scrub_state_e;
  typedef enum logic [1:0] {ECC_OK, ECC_SINGLE, ECC_DOUBLE} ecc_status_e;

  function automatic logic [31:0][6:0] secded_cols();
    logic [31:0][6:0] cols;
    logic [5:0]       n;
    logic [6:0]       c;
    cols = '0;
    n    = '0;
    for (int v = 0; v < 128; v++) begin
      c = 7'(v);
      if (!n[5] && $countones(c) == 3) begin
        cols[n[4:0]] = c;
        n = n + 6'd1;
      end
    end
    return cols;
  endfunction

  localparam logic [31:0][6:0] SecdedCols = secded_cols();

  // Every column has odd weight, so an odd syndrome is a single flip and a non-zero even one is a double.
  function automatic ecc_status_e secded_status(input logic [6:0] syndrome);
    if (syndrome == '0) return ECC_OK;
    if (^syndrome) return ECC_SINGLE;
    return ECC_DOUBLE;
  endfunction

endpackage

// File: rtl/ecc_scrubber_err_log.sv
// Saturating fix/uncorrectable event counters and last-error address; clear wins over a same-cycle event.
module ecc_scrubber_err_log #(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cnt_clear_i,
  input  logic                 fix_i,
  input  logic                 uncorr_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic [31:0]          fix_cnt_o,
  output logic [31:0]          uncorr_cnt_o,
  output logic [AddrWidth-1:0] last_err_addr_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fix_cnt_o       <= '0;
      uncorr_cnt_o    <= '0;
      last_err_addr_o <= '0;
    end else begin
      if (cnt_clear_i) fix_cnt_o <= '0;
      else if (fix_i && fix_cnt_o != '1) fix_cnt_o <= fix_cnt_o + 32'd1;
      if (cnt_clear_i) uncorr_cnt_o <= '0;
      else if (uncorr_i && uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + 32'd1;
      if (fix_i || uncorr_i) last_err_addr_o <= addr_i;
    end
  end

endmodule

// File: rtl/prim_secded_39_32_dec.sv
// Combinational SECDED (39,32) decoder: reports the syndrome and flips the data bit it points at.
module prim_secded_39_32_dec
  import ecc_scrubber_pkg::*;
(
  input  logic [38:0] data_i,
  output logic [31:0] data_o,
  output logic [6:0]  syndrome_o
);

  always_comb begin
    syndrome_o = data_i[38:32];
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) syndrome_o = syndrome_o ^ SecdedCols[i];
    end
    data_o = data_i[31:0];
    for (int i = 0; i < 32; i++) begin
      if (syndrome_o == SecdedCols[i]) data_o[i] = ~data_i[i];
    end
  end

endmodule

// File: rtl/prim_secded_39_32_enc.sv
// Combinational SECDED (39,32) encoder: data in [31:0], check bits in [38:32].
module prim_secded_39_32_enc
  import ecc_scrubber_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  logic [6:0] chk;

  always_comb begin
    chk = '0;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) chk = chk ^ SecdedCols[i];
    end
    data_o = {chk, data_i};
  end

endmodule

// File: rtl/ecc_scrubber.sv
// Bank arbiter + background SECDED scrubber; bus always wins, scrub costs 2 cycles (3 with fix, 1 bus stall).
// ECC_SCRUBBER_ERR_LOG_EN adds event counters, last error address and a counter clear.
module ecc_scrubber
  import ecc_scrubber_pkg::*;
#(
  parameter  int unsigned BankSize         = 256,
  parameter  int unsigned UnprotectedWidth = 32,
  parameter  int unsigned ProtectedWidth   = 39,
  localparam int unsigned BankAddWidth     = $clog2(BankSize)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      scrub_en_i,
  input  logic                      scrub_trigger_i,
  input  logic                      intc_req_i,
  input  logic                      intc_we_i,
  input  logic [BankAddWidth-1:0]   intc_add_i,
  input  logic [ProtectedWidth-1:0] intc_wdata_i,
  output logic                      intc_gnt_o,
  output logic [ProtectedWidth-1:0] intc_rdata_o,
  output logic                      bank_req_o,
  output logic                      bank_we_o,
  output logic [BankAddWidth-1:0]   bank_add_o,
  output logic [ProtectedWidth-1:0] bank_wdata_o,
  input  logic [ProtectedWidth-1:0] bank_rdata_i,
  output logic                      scrub_fix_o,
  output logic                      scrub_uncorr_o,
  output logic [BankAddWidth-1:0]   scrub_addr_o
`ifdef ECC_SCRUBBER_ERR_LOG_EN
  ,
  input  logic                      cnt_clear_i,
  output logic [31:0]               fix_cnt_o,
  output logic [31:0]               uncorr_cnt_o,
  output logic [BankAddWidth-1:0]   last_err_addr_o
`endif
);

  scrub_state_e                  state_q, state_d;
  logic                          pending_q;
  logic [BankAddWidth-1:0]       scrub_addr_q, lat_addr_q;
  logic [UnprotectedWidth-1:0]   fix_data_q, dec_data;
  logic [6:0]                    syndrome;
  logic [ProtectedWidth-1:0]     enc_data;
  ecc_status_e                   status;
  logic                          issue, advance, fix, uncorr, bus_hit;

  prim_secded_39_32_dec u_dec (
    .data_i     (bank_rdata_i),
    .data_o     (dec_data),
    .syndrome_o (syndrome)
  );

  prim_secded_39_32_enc u_enc (
    .data_i (fix_data_q),
    .data_o (enc_data)
  );

  assign status       = secded_status(syndrome);
  assign intc_rdata_o = bank_rdata_i;
  assign bus_hit      = intc_req_i && intc_we_i && (intc_add_i == lat_addr_q);

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    advance      = 1'b0;
    fix          = 1'b0;
    uncorr       = 1'b0;
    intc_gnt_o   = 1'b1;
    bank_req_o   = intc_req_i;
    bank_we_o    = intc_we_i;
    bank_add_o   = intc_add_i;
    bank_wdata_o = intc_wdata_i;
    unique case (state_q)
      IDLE: begin
        if (pending_q && !intc_req_i) begin
          issue        = 1'b1;
          bank_req_o   = 1'b1;
          bank_we_o    = 1'b0;
          bank_add_o   = scrub_addr_q;
          bank_wdata_o = '0;
          state_d      = READ;
        end
      end
      READ: begin
        state_d = IDLE;
        advance = 1'b1;
        if (status == ECC_DOUBLE) begin
          uncorr = 1'b1;
        end else if (status == ECC_SINGLE && !bus_hit) begin
          // A granted bus write to this word supersedes the correction.
          advance = 1'b0;
          state_d = WB;
        end
      end
      WB: begin
        intc_gnt_o   = 1'b0;
        bank_req_o   = 1'b1;
        bank_we_o    = 1'b1;
        bank_add_o   = lat_addr_q;
        bank_wdata_o = enc_data;
        fix          = 1'b1;
        advance      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      intc_gnt_o   = 1'b0;
      bank_req_o   = 1'b0;
      bank_we_o    = 1'b0;
      bank_add_o   = '0;
      bank_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      scrub_addr_q <= '0;
      lat_addr_q   <= '0;
      fix_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= scrub_en_i && (pending_q ? !issue : scrub_trigger_i);
      if (issue) lat_addr_q <= scrub_addr_q;
      if (state_q == READ) fix_data_q <= dec_data;
      if (advance) begin
        scrub_addr_q <= (scrub_addr_q == BankAddWidth'(BankSize - 1)) ? '0
                                                                     : scrub_addr_q + 1'b1;
      end
    end
  end

  assign scrub_fix_o    = fix;
  assign scrub_uncorr_o = uncorr;
  assign scrub_addr_o   = scrub_addr_q;

`ifdef ECC_SCRUBBER_ERR_LOG_EN
  ecc_scrubber_err_log #(
    .AddrWidth (BankAddWidth)
  ) u_err_log (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cnt_clear_i     (cnt_clear_i),
    .fix_i           (fix),
    .uncorr_i        (uncorr),
    .addr_i          (lat_addr_q),
    .fix_cnt_o       (fix_cnt_o),
    .uncorr_cnt_o    (uncorr_cnt_o),
    .last_err_addr_o (last_err_addr_o)
  );
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// Bench: two scrubbers (16-word and 5-word banks) with behavioural latency-1 SRAMs; scrub reads are scoreboarded.
module tb_ecc_scrubber;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en;
  // 16-word instance
  logic        trig, req, we, gnt, b_req, b_we, fix, uncorr;
  logic [3:0]  add, b_add, saddr;
  logic [38:0] wdata, rdata, b_wdata, b_rdata;
  logic [38:0] mem_a [16];
  // 5-word instance
  logic        trig2, req2, we2, gnt2, b2_req, b2_we, fix2, uncorr2;
  logic [2:0]  add2, b2_add, saddr2;
  logic [38:0] wdata2, rdata2, b2_wdata, b2_rdata;
  logic [38:0] mem_b [8];
`ifdef ECC_SCRUBBER_ERR_LOG_EN
  logic        clr, clr2;
  logic [31:0] fcnt, ucnt, fcnt2, ucnt2;
  logic [3:0]  lerr;
  logic [2:0]  lerr2;
`endif

  ecc_scrubber #(.BankSize(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scrub_en_i(en), .scrub_trigger_i(trig),
    .intc_req_i(req), .intc_we_i(we), .intc_add_i(add), .intc_wdata_i(wdata),
    .intc_gnt_o(gnt), .intc_rdata_o(rdata),
    .bank_req_o(b_req), .bank_we_o(b_we), .bank_add_o(b_add), .bank_wdata_o(b_wdata),
    .bank_rdata_i(b_rdata), .scrub_fix_o(fix), .scrub_uncorr_o(uncorr), .scrub_addr_o(saddr)
`ifdef ECC_SCRUBBER_ERR_LOG_EN
    , .cnt_clear_i(clr), .fix_cnt_o(fcnt), .uncorr_cnt_o(ucnt), .last_err_addr_o(lerr)
`endif
  );

  ecc_scrubber #(.BankSize(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .scrub_en_i(en), .scrub_trigger_i(trig2),
    .intc_req_i(req2), .intc_we_i(we2), .intc_add_i(add2), .intc_wdata_i(wdata2),
    .intc_gnt_o(gnt2), .intc_rdata_o(rdata2),
    .bank_req_o(b2_req), .bank_we_o(b2_we), .bank_add_o(b2_add), .bank_wdata_o(b2_wdata),
    .bank_rdata_i(b2_rdata), .scrub_fix_o(fix2), .scrub_uncorr_o(uncorr2), .scrub_addr_o(saddr2)
`ifdef ECC_SCRUBBER_ERR_LOG_EN
    , .cnt_clear_i(clr2), .fix_cnt_o(fcnt2), .uncorr_cnt_o(ucnt2), .last_err_addr_o(lerr2)
`endif
  );

  always @(posedge clk) if (b_req) begin
    if (b_we) mem_a[b_add] <= b_wdata;
    else b_rdata <= mem_a[b_add];
  end
  always @(posedge clk) if (b2_req) begin
    if (b2_we) mem_b[b2_add] <= b2_wdata;
    else b2_rdata <= mem_b[b2_add];
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: expected scrub-read addresses, pushed with each trigger.
  logic [3:0] exp_q[$];
  logic [2:0] exp_qb[$];
  int cyc_n = 0;
  int rd_cnt, wr_cnt, fix_s, unc_s, rd_cyc, wr_cyc, fix_cyc;
  logic [3:0]  wr_addr;
  logic [38:0] wr_dat;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (b_req && !b_we && !req) begin
      rd_cnt++;
      rd_cyc = cyc_n;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scrub_rd: unexpected scrub read of %0d, expected none", b_add);
      end else check("scrub_rd_addr", 64'(b_add), 64'(exp_q.pop_front()));
    end
    if (b_req && b_we && !gnt) begin
      wr_cnt++; wr_cyc = cyc_n; wr_addr = b_add; wr_dat = b_wdata;
    end
    if (fix) begin fix_s++; fix_cyc = cyc_n; end
    if (uncorr) unc_s++;
    if (b2_req && !b2_we && !req2) begin
      if (exp_qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scrub5_rd: unexpected scrub read of %0d, expected none", b2_add);
      end else check("scrub5_rd_addr", 64'(b2_add), 64'(exp_qb.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    rd_cnt = 0; wr_cnt = 0; fix_s = 0; unc_s = 0; rd_cyc = 0; wr_cyc = -1; fix_cyc = -2;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [38:0] d);
    cyc(); req = 1; we = 1; add = a; wdata = d;
    @(negedge clk); check("wr_gnt", 64'(gnt), 64'd1);
    cyc(); req = 0; we = 0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [38:0] d);
    cyc(); req = 1; we = 0; add = a;
    cyc(); req = 0;
    @(negedge clk); d = rdata;
  endtask

  task automatic scrub(input logic [3:0] a);
    exp_q.push_back(a);
    cyc(); trig = 1;
    cyc(); trig = 0;
    repeat (5) cyc();
  endtask

  typedef struct {
    logic [38:0] init;
    logic        exp_fix;
    logic        exp_unc;
    logic [38:0] final_w;
  } vec_t;
  vec_t tab[16];

  logic [38:0] rd;
  int fix_tot, unc_tot;

  initial begin
    rst_n = 0; en = 1; trig = 0; req = 1; we = 1; add = 4'd5; wdata = 39'h1234;
    trig2 = 0; req2 = 0; we2 = 0; add2 = '0; wdata2 = '0;
`ifdef ECC_SCRUBBER_ERR_LOG_EN
    clr = 0; clr2 = 0;
`endif
    for (int i = 0; i < 16; i++) tab[i] = '{39'h0, 1'b0, 1'b0, 39'h0};
    tab[2]  = '{39'h00_0000_0001, 1'b1, 1'b0, 39'h0};
    tab[5]  = '{39'h00_0002_0000, 1'b1, 1'b0, 39'h0};
    tab[7]  = '{39'h08_0000_0000, 1'b1, 1'b0, 39'h0};
    tab[9]  = '{39'h00_0010_0008, 1'b0, 1'b1, 39'h00_0010_0008};
    tab[11] = '{39'h22_0000_0000, 1'b0, 1'b1, 39'h22_0000_0000};
    tab[13] = '{39'h00_8000_0000, 1'b1, 1'b0, 39'h0};
    tab[15] = '{39'h40_0000_0001, 1'b0, 1'b1, 39'h40_0000_0001};

    // Reset: bus request asserted, must not reach the bank.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_bank", 64'({b_req, b_we, b_add, b_wdata}), 64'd0);
    check("rst_flags", 64'({fix, uncorr}), 64'd0);
    check("rst_saddr", 64'(saddr), 64'd0);
    cyc(); rst_n = 1; req = 0; we = 0;
    clr_mon();

    for (int i = 0; i < 16; i++) bus_write(4'(i), tab[i].init);

    // Walk the pointer over every word; the table decides what each scrub must do.
    fix_tot = 0; unc_tot = 0;
    for (int i = 0; i < 16; i++) begin
      clr_mon();
      scrub(4'(i));
      check("scrub_issued", 64'(exp_q.size()), 64'd0);
      check("fix_pulse", 64'(fix_s), 64'(tab[i].exp_fix));
      check("uncorr_pulse", 64'(unc_s), 64'(tab[i].exp_unc));
      check("wb_count", 64'(wr_cnt), 64'(tab[i].exp_fix));
      if (tab[i].exp_fix) begin
        fix_tot++;
        check("wb_addr", 64'(wr_addr), 64'(i));
        check("wb_data", 64'(wr_dat), 64'h0);
        check("wb_latency", 64'(wr_cyc - rd_cyc), 64'd2);
        check("fix_with_wb", 64'(fix_cyc), 64'(wr_cyc));
      end
      if (tab[i].exp_unc) unc_tot++;
      check("saddr_next", 64'(saddr), 64'((i + 1) % 16));
    end
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), rd);
      check("readback", 64'(rd), 64'(tab[i].final_w));
    end
`ifdef ECC_SCRUBBER_ERR_LOG_EN
    check("log_fix_cnt", 64'(fcnt), 64'(fix_tot));
    check("log_unc_cnt", 64'(ucnt), 64'(unc_tot));
    check("log_last", 64'(lerr), 64'd15);
    cyc(); clr = 1;
    cyc(); clr = 0;
    @(negedge clk);
    check("log_clear", 64'({fcnt, ucnt}), 64'd0);
`endif

    // Bus busy for 4 cycles with two triggers: one scrub, only after the request drops.
    clr_mon();
    exp_q.push_back(4'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); req = 1; we = 0; add = 4'd7; trig = (k == 0 || k == 2);
      @(negedge clk);
      check("busy_gnt", 64'(gnt), 64'd1);
      check("busy_bank", 64'({b_req, b_we, b_add}), 64'({1'b1, 1'b0, 4'd7}));
    end
    cyc(); req = 0; trig = 0;
    @(negedge clk);
    check("busy_issue", 64'({b_req, b_we, b_add}), 64'({1'b1, 1'b0, 4'd0}));
    repeat (5) cyc();
    check("busy_one_scrub", 64'(rd_cnt), 64'd1);
    check("busy_saddr", 64'(saddr), 64'd1);

    // Bus write to the scrub address during READ cancels the writeback.
    bus_write(4'd3, 39'h00_0000_1000);
    scrub(4'd1);
    scrub(4'd2);
    clr_mon();
    exp_q.push_back(4'd3);
    cyc(); trig = 1;
    cyc(); trig = 0;
    cyc(); req = 1; we = 1; add = 4'd3; wdata = 39'h00_0000_00AB;
    @(negedge clk);
    check("cancel_gnt", 64'(gnt), 64'd1);
    cyc(); req = 0; we = 0;
    repeat (4) cyc();
    check("cancel_no_wb", 64'(wr_cnt), 64'd0);
    check("cancel_no_fix", 64'(fix_s), 64'd0);
    check("cancel_saddr", 64'(saddr), 64'd4);
    bus_read(4'd3, rd);
    check("cancel_readback", 64'(rd), 64'h00_0000_00AB);

    // Reset during READ of a single-error word: no writeback, pointer restarts.
    bus_write(4'd4, 39'h00_0000_0100);
    clr_mon();
    exp_q.push_back(4'd4);
    cyc(); trig = 1;
    cyc(); trig = 0;
    cyc(); rst_n = 0; req = 1; we = 1; add = 4'd4; wdata = 39'h5;
    @(negedge clk);
    check("midrst_bank_req", 64'(b_req), 64'd0);
    check("midrst_gnt", 64'(gnt), 64'd0);
    cyc(); req = 0; we = 0;
    cyc(); rst_n = 1;
    repeat (4) cyc();
    check("midrst_no_wb", 64'({wr_cnt, fix_s}), 64'd0);
    check("midrst_saddr", 64'(saddr), 64'd0);
    bus_read(4'd4, rd);
    check("midrst_word", 64'(rd), 64'h00_0000_0100);

    // Disabled scrubber ignores triggers; disabling after issue lets the scrub finish.
    clr_mon();
    cyc(); en = 0; trig = 1;
    cyc(); trig = 0;
    repeat (4) cyc();
    check("dis_no_rd", 64'(rd_cnt), 64'd0);
    check("dis_saddr", 64'(saddr), 64'd0);
    clr_mon();
    exp_q.push_back(4'd0);
    cyc(); en = 1; trig = 1;
    cyc(); trig = 0; en = 0;
    repeat (5) cyc();
    check("endrop_one_rd", 64'(rd_cnt), 64'd1);
    check("endrop_saddr", 64'(saddr), 64'd1);
    en = 1;

    // 5-word bank: pointer wraps 4 -> 0.
    for (int a = 0; a < 5; a++) begin
      cyc(); req2 = 1; we2 = 1; add2 = 3'(a); wdata2 = '0;
    end
    cyc(); req2 = 0; we2 = 0;
    for (int k = 0; k < 10; k++) begin
      exp_qb.push_back(3'(k % 5));
      cyc(); trig2 = 1;
      cyc(); trig2 = 0;
      repeat (3) cyc();
      check("b5_saddr", 64'(saddr2), 64'((k + 1) % 5));
    end
    check("b5_all_issued", 64'(exp_qb.size()), 64'd0);
    check("b5_no_flags", 64'({fix2, uncorr2, gnt2}), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
